cache_refill_ctrl: RTL and testbench

//  Sequencing controller for the direct-mapped line cache. Owns the tag/valid/data arrays,

---
 rtl/cache_refill_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
// Direct-mapped line cache controller: hit/miss lookup, whole-line refill on read miss,
// write-through stores without allocation, and saturating hit/miss statistics.
module cache_refill_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ready,
  output logic                  cpu_done,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_hit,
  input  logic                  flush,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [15:0]           hit_cnt,
  output logic [15:0]           miss_cnt
);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - OFF_W;
  localparam int DA_W  = IDX_W + OFF_W;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_REFILL, S_WTHRU, S_DONE} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic                  we_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic                  hit_reg;
  logic                  first_reg;
  logic                  gap_reg;
  logic                  rdata_seen_reg;
  logic [OFF_W-1:0]      word_reg;
  logic [15:0]           hit_cnt_reg, miss_cnt_reg;

  logic [TAG_W-1:0]      tag_mem  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_mem [NUM_LINES*LINE_WORDS];
  logic [DATA_WIDTH-1:0] ram_rd;
  logic [NUM_LINES-1:0]  valid_reg;

  logic [TAG_W-1:0]      addr_tag;
  logic [IDX_W-1:0]      addr_idx;
  logic [OFF_W-1:0]      addr_off;
  logic                  lookup_hit;

  logic                  accept, flush_clear, refill_last, rd_en;
  logic                  ram_we;
  logic [DA_W-1:0]       ram_waddr;
  logic [DATA_WIDTH-1:0] ram_wdata;

  assign addr_tag   = addr_reg[ADDR_WIDTH-1 -: TAG_W];
  assign addr_idx   = addr_reg[OFF_W +: IDX_W];
  assign addr_off   = addr_reg[OFF_W-1:0];
  assign lookup_hit = valid_reg[addr_idx] && (tag_mem[addr_idx] == addr_tag);
  assign rd_en      = (state_reg == S_LOOKUP) && !we_reg && lookup_hit;

  assign cpu_done  = (state_reg == S_DONE);
  assign cpu_rdata = rdata_seen_reg ? ram_rd : '0;
  assign cpu_hit   = hit_reg;
  assign hit_cnt   = hit_cnt_reg;
  assign miss_cnt  = miss_cnt_reg;

  always_comb begin
    state_next  = state_reg;
    cpu_ready   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    accept      = 1'b0;
    flush_clear = 1'b0;
    refill_last = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = '0;
    ram_wdata   = '0;
    case (state_reg)
      S_IDLE: begin
        if (flush) begin
          flush_clear = 1'b1;
        end else begin
          cpu_ready = 1'b1;
          if (cpu_req) begin
            accept     = 1'b1;
            state_next = S_LOOKUP;
          end
        end
      end
      S_LOOKUP: begin
        if (we_reg) begin
          if (lookup_hit) begin
            ram_we    = 1'b1;
            ram_waddr = {addr_idx, addr_off};
            ram_wdata = wdata_reg;
          end
          state_next = S_WTHRU;
        end else if (lookup_hit) begin
          state_next = S_DONE;
        end else begin
          state_next = S_REFILL;
        end
      end
      S_REFILL: begin
        // gap_reg forces the one idle cycle between consecutive word reads
        if (!gap_reg) begin
          mem_req  = 1'b1;
          mem_addr = {addr_tag, addr_idx, word_reg};
          if (mem_ack) begin
            ram_we    = 1'b1;
            ram_waddr = {addr_idx, word_reg};
            ram_wdata = mem_rdata;
            if (word_reg == OFF_W'(LINE_WORDS-1)) begin
              refill_last = 1'b1;
              state_next  = S_LOOKUP;
            end
          end
        end
      end
      S_WTHRU: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_reg;
        mem_wdata = wdata_reg;
        if (mem_ack) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      addr_reg       <= '0;
      we_reg         <= 1'b0;
      wdata_reg      <= '0;
      hit_reg        <= 1'b0;
      first_reg      <= 1'b0;
      gap_reg        <= 1'b0;
      rdata_seen_reg <= 1'b0;
      word_reg       <= '0;
      hit_cnt_reg    <= '0;
      miss_cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg  <= cpu_addr;
        we_reg    <= cpu_we;
        wdata_reg <= cpu_wdata;
        first_reg <= 1'b1;
      end
      if (rd_en) rdata_seen_reg <= 1'b1;
      if (state_reg == S_LOOKUP) begin
        first_reg <= 1'b0;
        word_reg  <= '0;
        gap_reg   <= 1'b0;
        // the re-lookup after a refill must not overwrite the miss verdict
        if (first_reg) begin
          hit_reg <= lookup_hit;
          if (lookup_hit) begin
            if (hit_cnt_reg != 16'hFFFF) hit_cnt_reg <= hit_cnt_reg + 16'd1;
          end else begin
            if (miss_cnt_reg != 16'hFFFF) miss_cnt_reg <= miss_cnt_reg + 16'd1;
          end
        end
      end
      if (state_reg == S_REFILL) begin
        if (gap_reg) begin
          gap_reg <= 1'b0;
        end else if (mem_ack) begin
          gap_reg  <= 1'b1;
          word_reg <= word_reg + OFF_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (refill_last) tag_mem[addr_idx] <= addr_tag;
  end

  always_ff @(posedge clk) begin
    if (ram_we) data_mem[ram_waddr] <= ram_wdata;
    if (rd_en) ram_rd <= data_mem[{addr_idx, addr_off}];
  end

  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
    logic valid_bit;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_bit <= 1'b0;
      end else if (flush_clear) begin
        valid_bit <= 1'b0;
      end else if (refill_last && (addr_idx == IDX_W'(gi))) begin
        valid_bit <= 1'b1;
      end
    end
    assign valid_reg[gi] = valid_bit;
  end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized scoreboard bench for cache_refill_ctrl against a line-level cache model
// and a golden memory image; a RAM responder checks every bus transaction.
module tb_cache_refill_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, flush = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        cpu_ready, cpu_done, cpu_hit;
  logic [7:0]  cpu_rdata;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic [15:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  cache_refill_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .NUM_LINES(16), .LINE_WORDS(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
    .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct { logic we; logic [15:0] addr; logic [7:0] wdata; } mem_op_t;
  typedef struct { logic [7:0] rdata; logic hit; } cpu_exp_t;
  mem_op_t  mem_q[$];
  cpu_exp_t cpu_q[$];

  logic [7:0] ram    [65536];
  logic [7:0] golden [65536];

  // reference model: which line holds which tag, plus expected statistics
  bit         mvalid [16];
  logic [9:0] mtag   [16];
  int         exp_hit = 0, exp_miss = 0;
  logic [7:0] last_rdata = '0;

  // RAM responder: ack after a (random or fixed) number of wait cycles
  int ack_delay = -1;
  int wait_cnt = 0, target = 0, acks_seen = 0;
  always @(negedge clk) begin
    if (reset) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end else if (mem_ack) begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
      check("mem_gap", 32'(mem_req), 32'd0);
    end else if (mem_req) begin
      if (wait_cnt == 0) target = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
      if (wait_cnt >= target) begin
        if (mem_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_mem_req: got addr 0x%0h we %0d expected none", mem_addr, mem_we);
        end else begin
          mem_op_t e;
          e = mem_q.pop_front();
          check("mem_we", 32'(mem_we), 32'(e.we));
          check("mem_addr", 32'(mem_addr), 32'(e.addr));
          if (e.we) check("mem_wdata", 32'(mem_wdata), 32'(e.wdata));
        end
        if (mem_we) ram[mem_addr] = mem_wdata;
        else mem_rdata = ram[mem_addr];
        mem_ack = 1'b1;
        acks_seen++;
      end else begin
        wait_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && cpu_done) begin
      if (cpu_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_done: got rdata 0x%0h expected no completion", cpu_rdata);
      end else begin
        cpu_exp_t e;
        e = cpu_q.pop_front();
        check("cpu_rdata", 32'(cpu_rdata), 32'(e.rdata));
        check("cpu_hit", 32'(cpu_hit), 32'(e.hit));
      end
    end
  end

  task automatic predict(input bit we, input logic [15:0] a, input logic [7:0] wd, output bit hit);
    logic [3:0] idx;
    logic [9:0] tg;
    idx = a[5:2];
    tg  = a[15:6];
    hit = mvalid[idx] && (mtag[idx] == tg);
    if (hit) begin if (exp_hit < 65535) exp_hit++; end
    else     begin if (exp_miss < 65535) exp_miss++; end
    if (we) begin
      mem_q.push_back('{1'b1, a, wd});
      golden[a] = wd;
    end else begin
      if (!hit) begin
        for (int k = 0; k < 4; k++) mem_q.push_back('{1'b0, {tg, idx, 2'(k)}, 8'h00});
        mvalid[idx] = 1'b1;
        mtag[idx]   = tg;
      end
      last_rdata = golden[a];
    end
    cpu_q.push_back('{last_rdata, hit});
  endtask

  task automatic issue(input bit we, input logic [15:0] a, input logic [7:0] wd,
                       output time t_acc, output bit ok);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
    ok = 1'b0;
    t_acc = 0;
    for (int i = 0; i < 50; i++) begin
      if (cpu_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got cpu_ready 0 expected 1");
    end else begin
      @(posedge clk);
      t_acc = $time;
    end
    #1 cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic wait_done(output time t_done, output bit ok);
    ok = 1'b0;
    t_done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cpu_done) begin ok = 1'b1; t_done = $time; break; end
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no cpu_done expected one");
    end
  endtask

  task automatic access(input bit we, input logic [15:0] a, input logic [7:0] wd);
    bit  hit, ok;
    time t_acc, t_done;
    predict(we, a, wd, hit);
    issue(we, a, wd, t_acc, ok);
    if (!ok) return;
    wait_done(t_done, ok);
    if (!ok) return;
    if (!we && hit) check("hit_latency", 32'((t_done - t_acc + 5) / 10), 32'd2);
    #1;
    check("hit_cnt", 32'(hit_cnt), 32'(exp_hit));
    check("miss_cnt", 32'(miss_cnt), 32'(exp_miss));
    $display("[TB] %s addr=0x%04h wdata=0x%02h exp_rdata=0x%02h exp_hit=%0d",
             we ? "store" : "load ", a, wd, last_rdata, hit);
  endtask

  task automatic flush_idle(input bit with_req);
    @(negedge clk);
    flush = 1'b1;
    cpu_req = with_req; cpu_we = 1'b0; cpu_addr = 16'h0040;
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    #1 check("flush_ready", 32'(cpu_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0; cpu_req = 1'b0;
    #1 check("flush_idle_ready", 32'(cpu_ready), 32'd1);
    $display("[TB] flush with_req=%0d", with_req);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit  hit, ok;
    time t_acc;
    int  base;
    for (int n = 0; n < 65536; n++) begin
      ram[n] = 8'(n);
      golden[n] = 8'(n);
    end
    for (int i = 0; i < 16; i++) begin mvalid[i] = 1'b0; mtag[i] = '0; end

    #12;
    check("rst_ready", 32'(cpu_ready), 32'd1);
    check("rst_done", 32'(cpu_done), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    access(1'b0, 16'h0125, 8'h00);
    access(1'b0, 16'h0126, 8'h00);
    access(1'b1, 16'h0126, 8'hAB);
    access(1'b0, 16'h0126, 8'h00);
    access(1'b1, 16'h0F30, 8'h55);
    access(1'b0, 16'h0F30, 8'h00);
    flush_idle(1'b0);
    access(1'b0, 16'h0126, 8'h00);
    flush_idle(1'b1);
    access(1'b0, 16'h0125, 8'h00);

    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 19) == 0) flush_idle(1'($urandom_range(0, 1)));
      access(($urandom_range(0, 9) < 4), 16'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    // reset in the middle of a refill with two words already delivered
    ack_delay = 5;
    predict(1'b0, 16'hC0D4, 8'h00, hit);
    base = acks_seen;
    issue(1'b0, 16'hC0D4, 8'h00, t_acc, ok);
    for (int i = 0; i < 200; i++) begin
      if (acks_seen >= base + 2) break;
      @(negedge clk);
    end
    check("reset_two_acks", 32'(acks_seen - base), 32'd2);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_mem_req", 32'(mem_req), 32'd0);
    check("mid_rst_ready", 32'(cpu_ready), 32'd1);
    check("mid_rst_done", 32'(cpu_done), 32'd0);
    check("mid_rst_hit_cnt", 32'(hit_cnt), 32'd0);
    check("mid_rst_miss_cnt", 32'(miss_cnt), 32'd0);
    mem_q.delete();
    cpu_q.delete();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
    exp_hit = 0; exp_miss = 0; last_rdata = '0;
    $display("[TB] reset during refill");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ack_delay = -1;
    repeat (10) @(negedge clk);
    access(1'b0, 16'h0125, 8'h00);
    access(1'b0, 16'h0124, 8'h00);

    repeat (5) @(negedge clk);
    check("mem_q_empty", 32'(mem_q.size()), 32'd0);
    check("cpu_q_empty", 32'(cpu_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
